// File: rtl/unsaved_sys_pll_seq_pkg.sv
// Shared types and default constants for the system PLL reset/lock sequencer.
package unsaved_sys_pll_seq_pkg;

    // Sequencer states; the encoding is exported on state_o for debug.
    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAILED     = 3'd4
    } pll_seq_state_e;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 16;
    localparam int DEF_RETRY_W             = 2;

endpackage

// File: rtl/unsaved_sys_sync2.sv
// Two-flop synchronizer with synchronous clear, for any single-bit async input.
module unsaved_sys_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next values: shift the input through two stages, or flush both on clear.
    always_comb begin
        s1_d = clr ? 1'b0 : d;
        s2_d = clr ? 1'b0 : s1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    assign q = s2_q;

endmodule

// File: rtl/unsaved_sys_pll_reset_sequencer.sv
// PLL reset pulse / lock wait / lock stability sequencer with bounded retries.
// Outputs are decoded from registered state only, so no input reaches an
// output combinationally.
module unsaved_sys_pll_reset_sequencer
    import unsaved_sys_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W,
    parameter int RETRY_W             = DEF_RETRY_W
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    // Terminal counts: each counting state leaves on its last cycle, so the
    // counter never exceeds limit-1.
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    pll_seq_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               locked_s;

    // pll_locked is asynchronous to refclk; every decision uses the synced copy.
    unsaved_sys_sync2 u_lock_sync (
        .clk (refclk),
        .clr (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // State, counter, retry count and lock_lost pulse registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_ASSERT_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Next-state logic; relock_req overrides everything except rst.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        if (relock_req) begin
            state_d = ST_ASSERT_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock beats timeout when both land on the same cycle.
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAILED;
                        end else begin
                            state_d = ST_ASSERT_RST;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts the wait but does not cost a retry.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d     = ST_ASSERT_RST;
                        cnt_d       = '0;
                        retry_d     = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_ASSERT_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Moore output decode.
    always_comb begin
        pll_rst   = (state_q == ST_ASSERT_RST) || (state_q == ST_FAILED);
        ready     = (state_q == ST_RUN);
        fail      = (state_q == ST_FAILED);
        lock_lost = lock_lost_q;
        retry_cnt = retry_q;
        state_o   = state_q;
    end

endmodule

// File: doc/unsaved_sys_pll_reset_sequencer.md
# unsaved_sys_pll_reset_sequencer

Reset and lock sequencer for the SDRAM system PLL, running on the free-running 50 MHz board reference clock. It pulses the PLL reset and waits for lock with a timeout and bounded retries. It requires lock to stay stable before asserting `ready`, which releases the SDRAM controller and downstream logic from reset. On loss of lock it drops `ready` and re-sequences.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum cycles spent waiting for lock per attempt, 1 ms at 50 MHz (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before `ready` (≥1).
- `MAX_RETRIES`, 3: retries after the first attempt before declaring failure.
- `CNT_W`, 16: counter width; must hold max(all cycle parameters).
- `RETRY_W`, 2: width of `retry_cnt`; must hold `MAX_RETRIES`.

Ports:
- `refclk` in 1: sole clock, free-running 50 MHz reference.
- `rst` in 1: reset, synchronous, active-high.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to restart the full sequence.
- `pll_rst` out 1: drives the PLL `rst` input.
- `ready` out 1: PLL clocks valid; downstream reset release.
- `lock_lost` out 1: one-cycle pulse when lock drops while in RUN.
- `fail` out 1: retries exhausted.
- `retry_cnt` out RETRY_W: number of retries taken in the current sequence.
- `state_o` out 3: current state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to form `locked_s`. All decisions use `locked_s`.
- All outputs are registered or decoded from registered state (Moore), with no combinational paths from inputs.
  - `pll_rst` = 1 in ASSERT_RST and FAILED.
  - `ready` = 1 in RUN.
  - `fail` = 1 in FAILED.
- Priority: `rst` > `relock_req` > state logic.
- `rst`: state goes to ASSERT_RST; `cnt`, `retry_cnt`, `lock_lost` and both synchronizer flops are cleared. Reset values: `pll_rst`=1, `ready`=0, `lock_lost`=0, `fail`=0, `retry_cnt`=0.
- `relock_req`, in any state: go to ASSERT_RST and clear `cnt` and `retry_cnt`. No `lock_lost` pulse.

States:
- **ASSERT_RST**: stay for exactly `RST_PULSE_CYCLES` cycles, then go to WAIT_LOCK with `cnt` cleared.
- **WAIT_LOCK**:
  - If `locked_s`=1, go to STABLE with `cnt` cleared.
  - Otherwise, if `cnt` = `LOCK_TIMEOUT_CYCLES`-1:
    - If `retry_cnt` = `MAX_RETRIES`, go to FAILED.
    - Else increment `retry_cnt` and go to ASSERT_RST.
  - Otherwise increment `cnt`.
- **STABLE**:
  - If `locked_s`=0, return to WAIT_LOCK with `cnt` cleared. `retry_cnt` is unchanged, and this is not counted as a retry.
  - After `LOCK_STABLE_CYCLES` consecutive cycles with `locked_s`=1, go to RUN.
- **RUN**:
  - If `locked_s`=0, go to ASSERT_RST, pulse `lock_lost` for the transition cycle, and clear `retry_cnt`.
- **FAILED**: terminal. Only `rst` or `relock_req` exits.

Counters saturate by construction: `cnt` never exceeds the active state's limit minus 1.

## Timing
- Synchronizer latency is 2 cycles from the `pll_locked` edge to `locked_s`.
- After the first edge sampling `rst`=0, `pll_rst` stays high for exactly `RST_PULSE_CYCLES` cycles.
- With `locked_s` already 1 on WAIT_LOCK entry, the sequence is: WAIT_LOCK 1 cycle, STABLE `LOCK_STABLE_CYCLES` cycles, then RUN. `ready` rises `RST_PULSE_CYCLES`+1+`LOCK_STABLE_CYCLES` cycles after reset release.
- A timed-out attempt spends exactly `LOCK_TIMEOUT_CYCLES` cycles in WAIT_LOCK.
- FAILED is reached after `MAX_RETRIES`+1 attempts.
- Lock loss in RUN: `ready` falls, `lock_lost`=1 and `pll_rst` rises all on the edge after `locked_s` is sampled 0. `lock_lost` returns to 0 on the next edge.
- Lock arriving on the timeout cycle: lock wins, and the state goes to STABLE.
- `relock_req` coinciding with lock loss in RUN: `relock_req` wins, with no `lock_lost` pulse.

## Structure
- Package `unsaved_sys_pll_seq_pkg` contains:
  - The state enum: ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4 (also drives `state_o`).
  - The default parameter constants.
- Sub-module `unsaved_sys_sync2` is the 2-FF synchronizer with synchronous clear. It is reused for other asynchronous inputs.

## Test plan
Test parameters: RST_PULSE=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2.
- **Nominal:** `pll_locked`=1 before reset release -> `pll_rst` high for 4 cycles; `ready` rises at cycle 13; `retry_cnt`=0.
- **Failure:** `pll_locked` held 0 -> 3 attempts, each with 4 cycles of `pll_rst` followed by 20 cycles of WAIT_LOCK; `retry_cnt` steps 1, 2; then `fail`=1, `pll_rst`=1, `ready`=0.
- **Late lock:** lock appears during the 2nd attempt -> `ready` rises 8 cycles after STABLE entry; `retry_cnt`=1.
- **Glitch during STABLE:** `locked_s` low for 1 cycle at STABLE cycle 5 -> state goes to WAIT_LOCK, then a full 8-cycle stable window; `retry_cnt` unchanged.
- **Lock loss in RUN:** `pll_locked` drops -> one-cycle `lock_lost`, `ready`=0, `pll_rst`=1; nominal re-sequence follows.
- **Recovery from FAILED:** `relock_req` in FAILED -> `fail`=0, `retry_cnt`=0, 4-cycle `pll_rst` pulse. `rst` asserted mid-STABLE -> all outputs at reset values on the next edge.
